// File: rtl/keypad_pkg.sv
// Shared types, sizes and bit helpers for the 4x4 keypad matrix scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned FRAME_W  = NUM_ROWS * NUM_COLS;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned STABLE_W = 4;

  // Key report handed to the digit/BCD logic.
  typedef struct packed {
    logic [KEY_W-1:0] code;
    logic             valid;
    logic             held;
  } key_report_t;

  // Bit position of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [KEY_W-1:0] onehot_index(input logic [FRAME_W-1:0] vec);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < FRAME_W; i++) begin
      if (vec[i]) begin
        idx = KEY_W'(i);
      end
    end
    return idx;
  endfunction

  // True when at most one bit of the vector is set.
  function automatic logic onehot_or_zero(input logic [FRAME_W-1:0] vec);
    return (vec & (vec - FRAME_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_CYCLES clocks.
// The tick is registered and coincides with the counter's terminal count.
module scan_tick_gen #(
  parameter int unsigned TICK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned      CNT_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_CYCLES - 2);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_CYCLES-1; raise tick one cycle early so it lines up with the terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: walks one active-low column per tick, assembles
// whole-matrix frames, debounces them and reports single new key presses.
// TICK_CYCLES = CLK_FREQ/SCAN_HZ must be >= 4; DEBOUNCE_SCANS in 2..15.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int unsigned         TICK_CYCLES = CLK_FREQ / SCAN_HZ;
  localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(DEBOUNCE_SCANS - 1);
  localparam logic [COL_W-1:0]    LAST_COL    = COL_W'(NUM_COLS - 1);
  localparam logic [NUM_COLS-1:0] COL0_SEL    = NUM_COLS'(1);

  logic                tick;
  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [COL_W-1:0]    col;
  logic [FRAME_W-1:0]  frame;
  logic [FRAME_W-1:0]  prev_frame;
  logic [FRAME_W-1:0]  committed;
  logic [STABLE_W-1:0] stable_cnt;
  key_report_t         report;

  logic [NUM_ROWS-1:0] rows_c;
  logic [FRAME_W-1:0]  frame_c;
  logic [COL_W-1:0]    col_nxt_c;
  logic                frame_done_c;
  logic                frame_eq_c;
  logic [STABLE_W-1:0] stable_nxt_c;
  logic                commit_c;
  logic                one_hot_c;
  logic                was_empty_c;
  logic [KEY_W-1:0]    bit_idx_c;
  logic [KEY_W-1:0]    code_c;

  // Column dwell timebase.
  scan_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchroniser for the asynchronous row lines; idle level is released (high).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Frame assembly, debounce decision and key decode for the current tick.
  always_comb begin
    rows_c       = ~row_sync;
    frame_c      = frame;
    frame_c[col*NUM_ROWS +: NUM_ROWS] = rows_c;
    col_nxt_c    = col + COL_W'(1);
    frame_done_c = tick && (col == LAST_COL);
    frame_eq_c   = (frame_c == prev_frame);
    stable_nxt_c = '0;
    if (frame_eq_c) begin
      stable_nxt_c = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + STABLE_W'(1);
    end
    commit_c     = frame_done_c && frame_eq_c && (stable_nxt_c == STABLE_MAX);
    one_hot_c    = (frame_c != '0) && onehot_or_zero(frame_c);
    was_empty_c  = (committed == '0);
    // Frame bit index is col*NUM_ROWS + row; the reported code is row*NUM_COLS + col.
    bit_idx_c    = onehot_index(frame_c);
    code_c       = KEY_W'((32'(bit_idx_c) % NUM_ROWS) * NUM_COLS + 32'(bit_idx_c) / NUM_ROWS);
  end

  // Column walk: advance the driven column on every tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col   <= '0;
      col_n <= ~COL0_SEL;
    end else if (tick) begin
      col   <= col_nxt_c;
      col_n <= ~(COL0_SEL << col_nxt_c);
    end
  end

  // Capture column samples; at frame end update the stability count and commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame      <= '0;
      prev_frame <= '0;
      committed  <= '0;
      stable_cnt <= '0;
    end else if (tick) begin
      frame <= frame_c;
      if (frame_done_c) begin
        prev_frame <= frame_c;
        stable_cnt <= stable_nxt_c;
        if (commit_c) begin
          committed <= frame_c;
        end
      end
    end
  end

  // Report register: strobe only on an empty-to-single-key commit, code sticks otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      report <= '0;
    end else begin
      report.valid <= 1'b0;
      if (commit_c) begin
        report.held  <= one_hot_c;
        report.valid <= one_hot_c && was_empty_c;
        if (one_hot_c) begin
          report.code <= code_c;
        end
      end
    end
  end

  assign key_code  = report.code;
  assign key_valid = report.valid;
  assign key_held  = report.held;

endmodule
